// File: rtl/fwd_scoreboard_pkg.sv
// Shared definitions for the forwarding scoreboard: fwd_sel encoding and stage helpers.
package fwd_scoreboard_pkg;

  // fwd_sel value k selects producer stage k; 0 selects the register file.
  localparam int FWD_NONE = 0;

  // Legacy two-stage encoding, still valid when DEPTH == 2.
  typedef enum logic [1:0] {
    FORWARD_NONE = 2'd0,
    FORWARD_MEM  = 2'd1,
    FORWARD_WB   = 2'd2
  } forward_sel_e;

  // A loaded value can be forwarded once it has reached stage load_ready.
  function automatic logic fwd_load_ready(input int stage, input int load_ready);
    return (stage >= load_ready);
  endfunction

endpackage

// File: rtl/fwd_scoreboard_prio_match.sv
// One read port checked against every in-flight destination tag; youngest producer wins.
module fwd_prio_match
  import fwd_scoreboard_pkg::*;
#(
  parameter int RW         = 3,
  parameter int DEPTH      = 2,
  parameter int LOAD_READY = 2,
  parameter int SW         = $clog2(DEPTH + 1)
) (
  input  logic                      rd_used,
  input  logic [RW-1:0]             rd_addr,
  input  logic [DEPTH-1:0]          tag_valid,
  input  logic [DEPTH-1:0]          tag_we,
  input  logic [DEPTH-1:0]          tag_load,
  input  logic [DEPTH-1:0][RW-1:0]  tag_rd,
  output logic [SW-1:0]             sel,
  output logic                      hazard
);

  logic [DEPTH-1:0] hit_s;

  // Per-stage match; register 0 is hardwired and never forwarded.
  always_comb begin
    hit_s = {DEPTH{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      hit_s[k] = rd_used && tag_valid[k] && tag_we[k]
                 && (tag_rd[k] != {RW{1'b0}}) && (tag_rd[k] == rd_addr);
    end
  end

  // Walk oldest to youngest so the youngest hit overwrites older ones.
  always_comb begin
    sel    = SW'(FWD_NONE);
    hazard = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (hit_s[k]) begin
        sel    = SW'(k + 1);
        hazard = tag_load[k] && !fwd_load_ready(k + 1, LOAD_READY);
      end else begin
        sel    = sel;
        hazard = hazard;
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// EX-stage forwarding scoreboard: destination tag pipe, per-port priority match, load-use stall.
// Optional statistics counters are built when FWD_STATS_EN is defined.
module fwd_scoreboard
  import fwd_scoreboard_pkg::*;
#(
  parameter int NUM_REGS   = 8,
  parameter int NUM_RD     = 3,
  parameter int DEPTH      = 2,
  parameter int LOAD_READY = 2,
  localparam int RW        = $clog2(NUM_REGS),
  localparam int SW        = $clog2(DEPTH + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         ex_valid,
  input  logic                         ex_we,
  input  logic                         ex_load,
  input  logic [RW-1:0]                ex_rd,
  input  logic [NUM_RD-1:0]            rd_used,
  input  logic [NUM_RD-1:0][RW-1:0]    rd_addr,
  input  logic                         pipe_hold,
  input  logic                         flush,
  output logic [NUM_RD-1:0][SW-1:0]    fwd_sel,
  output logic                         stall
`ifdef FWD_STATS_EN
  ,
  output logic [31:0]                  stat_stalls,
  output logic [31:0]                  stat_fwds
`endif
);

  typedef struct packed {
    logic          valid;
    logic          we;
    logic          load;
    logic [RW-1:0] rd;
  } tag_t;

  localparam tag_t TAG_BUBBLE = '{valid: 1'b0, we: 1'b0, load: 1'b0, rd: {RW{1'b0}}};

  if (DEPTH < 1) begin : g_bad_depth
    $error("fwd_scoreboard: DEPTH must be >= 1");
  end
  if ((LOAD_READY < 1) || (LOAD_READY > DEPTH)) begin : g_bad_load_ready
    $error("fwd_scoreboard: LOAD_READY must lie in 1..DEPTH");
  end

  tag_t                      tag_r [1:DEPTH];
  logic [DEPTH-1:0]          tag_valid_s;
  logic [DEPTH-1:0]          tag_we_s;
  logic [DEPTH-1:0]          tag_load_s;
  logic [DEPTH-1:0][RW-1:0]  tag_rd_s;
  logic [NUM_RD-1:0]         hazard_s;
  logic                      stall_s;

  // Flatten the tag pipe into per-field vectors for the match units.
  always_comb begin
    for (int k = 1; k <= DEPTH; k++) begin
      tag_valid_s[k-1] = tag_r[k].valid;
      tag_we_s[k-1]    = tag_r[k].we;
      tag_load_s[k-1]  = tag_r[k].load;
      tag_rd_s[k-1]    = tag_r[k].rd;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_port
    fwd_prio_match #(
      .RW         (RW),
      .DEPTH      (DEPTH),
      .LOAD_READY (LOAD_READY),
      .SW         (SW)
    ) u_match (
      .rd_used   (rd_used[i]),
      .rd_addr   (rd_addr[i]),
      .tag_valid (tag_valid_s),
      .tag_we    (tag_we_s),
      .tag_load  (tag_load_s),
      .tag_rd    (tag_rd_s),
      .sel       (fwd_sel[i]),
      .hazard    (hazard_s[i])
    );
  end

  assign stall_s = |hazard_s;
  assign stall   = stall_s;

  // Tag pipe: hold freezes everything; flush and stall inject a bubble into stage 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 1; k <= DEPTH; k++) begin
        tag_r[k] <= TAG_BUBBLE;
      end
    end else if (pipe_hold) begin
      for (int k = 1; k <= DEPTH; k++) begin
        tag_r[k] <= tag_r[k];
      end
    end else begin
      for (int k = DEPTH; k >= 2; k--) begin
        tag_r[k] <= tag_r[k-1];
      end
      if (flush || stall_s) begin
        tag_r[1] <= TAG_BUBBLE;
      end else begin
        tag_r[1] <= '{valid: ex_valid, we: ex_we, load: ex_load, rd: ex_rd};
      end
    end
  end

`ifdef FWD_STATS_EN
  logic any_fwd_s;

  assign any_fwd_s = |fwd_sel;

  // Saturating event counters; frozen while the pipe is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_stalls <= 32'd0;
      stat_fwds   <= 32'd0;
    end else if (!pipe_hold) begin
      if (stall_s && (stat_stalls != 32'hFFFF_FFFF)) begin
        stat_stalls <= stat_stalls + 32'd1;
      end
      if (any_fwd_s && (stat_fwds != 32'hFFFF_FFFF)) begin
        stat_fwds <= stat_fwds + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Table-driven bench for fwd_scoreboard (default parameters) with an expectation queue.
module tb_fwd_scoreboard;

  logic             clk;
  logic             rst_n;
  logic             ex_valid;
  logic             ex_we;
  logic             ex_load;
  logic [2:0]       ex_rd;
  logic [2:0]       rd_used;
  logic [2:0][2:0]  rd_addr;
  logic             pipe_hold;
  logic             flush;
  logic [2:0][1:0]  fwd_sel;
  logic             stall;
`ifdef FWD_STATS_EN
  logic [31:0]      stat_stalls;
  logic [31:0]      stat_fwds;
`endif

  fwd_scoreboard dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ex_valid  (ex_valid),
    .ex_we     (ex_we),
    .ex_load   (ex_load),
    .ex_rd     (ex_rd),
    .rd_used   (rd_used),
    .rd_addr   (rd_addr),
    .pipe_hold (pipe_hold),
    .flush     (flush),
    .fwd_sel   (fwd_sel),
    .stall     (stall)
`ifdef FWD_STATS_EN
    ,
    .stat_stalls (stat_stalls),
    .stat_fwds   (stat_fwds)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic            ev;
    logic            we;
    logic            ld;
    logic [2:0]      rd;
    logic [2:0]      used;
    logic [2:0][2:0] addr;
    logic            hold;
    logic            flush;
    logic [2:0][1:0] sel;
    logic            stall;
  } vec_t;

  typedef struct {
    logic [5:0] sel;
    logic       stall;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;
  vec_t vecs[20];

  function automatic vec_t mk(input logic ev, input logic we, input logic ld, input int rd,
                              input logic [2:0] used, input int a0, input int a1, input int a2,
                              input logic hold, input logic fl,
                              input int s0, input int s1, input int s2, input logic st);
    vec_t v;
    v.ev = ev; v.we = we; v.ld = ld; v.rd = 3'(rd);
    v.used = used;
    v.addr[0] = 3'(a0); v.addr[1] = 3'(a1); v.addr[2] = 3'(a2);
    v.hold = hold; v.flush = fl;
    v.sel[0] = 2'(s0); v.sel[1] = 2'(s1); v.sel[2] = 2'(s2);
    v.stall = st;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drive one cycle's inputs, queue the expectation, compare once outputs settle.
  task automatic apply(input vec_t v, input string name);
    exp_t e;
    ex_valid  = v.ev;   ex_we   = v.we;   ex_load = v.ld;  ex_rd = v.rd;
    rd_used   = v.used; rd_addr = v.addr;
    pipe_hold = v.hold; flush   = v.flush;
    exp_q.push_back('{sel: v.sel, stall: v.stall});
    #2;
    e = exp_q.pop_front();
    check({name, " fwd_sel"}, 32'(fwd_sel), 32'(e.sel));
    check({name, " stall"},   32'(stall),   32'(e.stall));
  endtask

  initial begin
`ifdef FWD_STATS_EN
    logic [31:0] base;
`endif
    //          ev we ld rd used    a0 a1 a2 hd fl  s0 s1 s2 st
    vecs[0]  = mk(1, 1, 0, 3, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[1]  = mk(1, 0, 0, 3, 3'b001, 3, 0, 0, 0, 0, 1, 0, 0, 0);
    vecs[2]  = mk(1, 0, 0, 1, 3'b001, 3, 0, 0, 0, 0, 2, 0, 0, 0);
    vecs[3]  = mk(1, 1, 0, 5, 3'b001, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[4]  = mk(1, 1, 0, 5, 3'b010, 0, 5, 0, 0, 0, 0, 1, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0, 3'b110, 0, 5, 5, 0, 0, 0, 1, 1, 0);
    vecs[6]  = mk(1, 1, 1, 4, 3'b010, 0, 5, 0, 0, 0, 0, 2, 0, 0);
    vecs[7]  = mk(1, 1, 0, 6, 3'b001, 4, 0, 0, 0, 0, 1, 0, 0, 1);
    vecs[8]  = mk(1, 1, 0, 6, 3'b001, 4, 0, 0, 0, 0, 2, 0, 0, 0);
    vecs[9]  = mk(1, 1, 1, 2, 3'b101, 6, 0, 0, 0, 0, 1, 0, 0, 0);
    vecs[10] = mk(1, 1, 0, 7, 3'b010, 2, 6, 0, 0, 0, 0, 2, 0, 0);
    vecs[11] = mk(1, 1, 0, 0, 3'b001, 2, 0, 0, 0, 0, 2, 0, 0, 0);
    vecs[12] = mk(1, 1, 0, 1, 3'b011, 0, 7, 0, 0, 1, 0, 2, 0, 0);
    vecs[13] = mk(0, 0, 0, 0, 3'b011, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[14] = mk(1, 1, 1, 4, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[15] = mk(1, 1, 0, 6, 3'b001, 4, 0, 0, 1, 0, 1, 0, 0, 1);
    vecs[16] = mk(1, 1, 0, 6, 3'b001, 4, 0, 0, 1, 0, 1, 0, 0, 1);
    vecs[17] = mk(1, 1, 0, 6, 3'b001, 4, 0, 0, 1, 0, 1, 0, 0, 1);
    vecs[18] = mk(1, 1, 0, 6, 3'b001, 4, 0, 0, 0, 0, 1, 0, 0, 1);
    vecs[19] = mk(1, 1, 0, 6, 3'b001, 4, 0, 0, 0, 0, 2, 0, 0, 0);

    rst_n = 1'b0;
    apply(mk(0, 0, 0, 0, 3'b001, 3, 0, 0, 0, 0, 0, 0, 0, 0), "reset");
`ifdef FWD_STATS_EN
    check("reset stat_stalls", stat_stalls, 32'd0);
    check("reset stat_fwds",   stat_fwds,   32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      apply(vecs[i], $sformatf("v%0d", i));
      @(negedge clk);
    end

    // Reset asserted while a load and an ALU producer are in flight.
    apply(mk(1, 1, 1, 4, 3'b001, 6, 0, 0, 0, 0, 1, 0, 0, 0), "pre_rst_load");
    @(negedge clk);
    apply(mk(0, 0, 0, 0, 3'b011, 4, 6, 0, 0, 0, 1, 2, 0, 1), "pre_rst");
    rst_n = 1'b0;
    apply(mk(0, 0, 0, 0, 3'b011, 4, 6, 0, 0, 0, 0, 0, 0, 0), "async_rst");
`ifdef FWD_STATS_EN
    check("mid_rst stat_stalls", stat_stalls, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    apply(mk(0, 0, 0, 0, 3'b011, 4, 6, 0, 0, 0, 0, 0, 0, 0), "post_rst");
    @(negedge clk);

`ifdef FWD_STATS_EN
    // Stall counter is frozen during hold and counts the released stall cycle once.
    apply(mk(1, 1, 1, 4, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0, 0), "st_load");
    @(negedge clk);
    base = stat_stalls;
    for (int h = 0; h < 3; h++) begin
      apply(mk(1, 1, 0, 6, 3'b001, 4, 0, 0, 1, 0, 1, 0, 0, 1), $sformatf("st_hold%0d", h));
      @(negedge clk);
      check($sformatf("st_hold%0d stat_stalls", h), stat_stalls, base);
    end
    apply(mk(1, 1, 0, 6, 3'b001, 4, 0, 0, 0, 0, 1, 0, 0, 1), "st_release");
    @(negedge clk);
    check("st_release stat_stalls", stat_stalls, base + 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
